// File: rtl/axi2ahb_pkg.sv
// Shared constants for the AXI-to-AHB bridge ID path: widths, FIFO depth,
// entry layout and arbitration grant encoding.
package axi2ahb_pkg;

    localparam int AXI_ID_WIDTH_DFLT = 8;

    // ID FIFO depth; the producer side also uses it as its outstanding limit.
    localparam int ID_FIFO_DEPTH = 128;

    // Entry layout is {is_write, id}: the write flag sits just above the ID.
    localparam int IS_WRITE_BIT_DFLT = AXI_ID_WIDTH_DFLT;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

endpackage

// File: rtl/axi_id_rr_arb2.sv
// Two-requester round-robin arbiter (write/read) with registered last-grant
// state; the pointer only moves when the granted request is actually taken.
module axi_id_rr_arb2
    import axi2ahb_pkg::*;
(
    input  logic wclk,
    input  logic resetn,
    input  logic req_w,
    input  logic req_r,
    input  logic accept,
    output logic grant_w,
    output logic grant_r
);

    grant_e last_grant_reg;

    // On contention the side that did not win last time gets the grant.
    assign grant_w = req_w & (~req_r | (last_grant_reg == GRANT_READ));
    assign grant_r = req_r & ~grant_w;

    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg <= GRANT_READ;
        end else if (accept) begin
            last_grant_reg <= grant_w ? GRANT_WRITE : GRANT_READ;
        end
    end

endmodule

// File: rtl/axi_id_enqueue.sv
// AXI-side producer of the ID path: arbitrates AW/AR handshakes, stages the
// tagged {is_write, id} entry toward the ID FIFO and bounds outstanding work.
module axi_id_enqueue
    import axi2ahb_pkg::*;
#(
    parameter int AXI_ID_WIDTH    = AXI_ID_WIDTH_DFLT,
    parameter int MAX_OUTSTANDING = ID_FIFO_DEPTH,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    wclk,
    input  logic                    resetn,
    input  logic                    awvalid,
    input  logic [AXI_ID_WIDTH-1:0] awid,
    output logic                    awready,
    input  logic                    arvalid,
    input  logic [AXI_ID_WIDTH-1:0] arid,
    output logic                    arready,
    output logic                    fifo_wr_en,
    output logic [AXI_ID_WIDTH:0]   fifo_data,
    input  logic                    fifo_full,
    input  logic                    rsp_done,
    output logic [CNT_W-1:0]        outstanding,
    output logic                    busy,
    output logic                    err_underflow
);

    localparam int              IS_WRITE_BIT = AXI_ID_WIDTH;
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic                    hold_vld_reg, hold_vld_next;
    logic [AXI_ID_WIDTH:0]   hold_data_reg, hold_data_next;
    logic [CNT_W-1:0]        outstanding_reg, outstanding_next;
    logic                    err_underflow_reg, err_underflow_next;

    logic                    grant_w, grant_r;
    logic                    push, can_acc, acc_w, acc_r, accept;
    logic [AXI_ID_WIDTH:0]   entry_sel;

    axi_id_rr_arb2 u_arb (
        .wclk    (wclk),
        .resetn  (resetn),
        .req_w   (awvalid),
        .req_r   (arvalid),
        .accept  (accept),
        .grant_w (grant_w),
        .grant_r (grant_r)
    );

    // The held entry drains in the same cycle a new one is accepted, so a
    // non-full FIFO sees one ID per cycle.
    assign push    = hold_vld_reg & ~fifo_full;
    assign can_acc = (~hold_vld_reg | push) & (outstanding_reg < MAX_CNT);
    assign acc_w   = awvalid & can_acc & grant_w;
    assign acc_r   = arvalid & can_acc & grant_r;
    assign accept  = acc_w | acc_r;

    // Reset gating is applied only at the outputs; the state is already
    // being held in reset, so internal accept decisions are don't-care then.
    assign awready    = resetn & acc_w;
    assign arready    = resetn & acc_r;
    assign fifo_wr_en = resetn & push;
    assign fifo_data  = hold_data_reg;

    assign outstanding   = outstanding_reg;
    assign busy          = (outstanding_reg != '0) | hold_vld_reg;
    assign err_underflow = err_underflow_reg;

    always_comb begin
        entry_sel                      = '0;
        entry_sel[IS_WRITE_BIT]        = grant_w;
        entry_sel[AXI_ID_WIDTH-1:0]    = grant_w ? awid : arid;
    end

    always_comb begin
        hold_vld_next  = hold_vld_reg;
        hold_data_next = hold_data_reg;
        if (accept) begin
            hold_vld_next  = 1'b1;
            hold_data_next = entry_sel;
        end else if (push) begin
            hold_vld_next  = 1'b0;
            hold_data_next = '0;
        end
    end

    // Increment is already capped by can_acc; decrement is capped at zero
    // and a stray completion at zero latches the sticky error instead.
    always_comb begin
        outstanding_next   = outstanding_reg;
        err_underflow_next = err_underflow_reg;
        case ({accept, rsp_done})
            2'b10: outstanding_next = outstanding_reg + CNT_ONE;
            2'b01: begin
                if (outstanding_reg != '0) begin
                    outstanding_next = outstanding_reg - CNT_ONE;
                end else begin
                    err_underflow_next = 1'b1;
                end
            end
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            hold_vld_reg      <= 1'b0;
            hold_data_reg     <= '0;
            outstanding_reg   <= '0;
            err_underflow_reg <= 1'b0;
        end else begin
            hold_vld_reg      <= hold_vld_next;
            hold_data_reg     <= hold_data_next;
            outstanding_reg   <= outstanding_next;
            err_underflow_reg <= err_underflow_next;
        end
    end

endmodule

// File: doc/axi_id_enqueue.md
Name: axi_id_enqueue

Overview:
- Producer side of the AXI-to-AHB ID path, in the AXI (wclk) domain.
- Accepts AXI AW and AR address handshakes and arbitrates between them, one grant per cycle.
- Pushes a tagged entry {is_write, id} into the clock-crossing ID FIFO's write port, honouring its full flag.
- Limits outstanding transactions with a credit counter that is released by response-completion pulses.

Parameters:
- AXI_ID_WIDTH, 8, width of awid/arid. FIFO entry width is AXI_ID_WIDTH+1.
- MAX_OUTSTANDING, 128, maximum accepted-but-not-completed transactions. Equals the ID FIFO depth.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- wclk  in  1  AXI-side clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- awvalid  in  1  AXI write-address valid.
- awid  in  AXI_ID_WIDTH  AXI write ID.
- awready  out  1  write-address accept.
- arvalid  in  1  AXI read-address valid.
- arid  in  AXI_ID_WIDTH  AXI read ID.
- arready  out  1  read-address accept.
- fifo_wr_en  out  1  ID FIFO write strobe.
- fifo_data  out  AXI_ID_WIDTH+1  entry {is_write, id}; bit [AXI_ID_WIDTH]=1 for a write.
- fifo_full  in  1  ID FIFO full flag, combinational, wclk domain.
- rsp_done  in  1  one-cycle pulse when a B response or R-last beat completes on AXI.
- outstanding  out  CNT_W  current outstanding count.
- busy  out  1  outstanding != 0 or holding register valid.
- err_underflow  out  1  sticky: rsp_done arrived while outstanding == 0.

Behaviour:
- Reset (resetn low, asynchronous): hold_vld=0, hold_data=0, outstanding=0, last_grant=READ, err_underflow=0.
- While resetn is low, awready, arready and fifo_wr_en are forced to 0.
- Holding register: one entry, hold_vld/hold_data.
  - fifo_wr_en = hold_vld & !fifo_full.
  - fifo_data = hold_data. It is 0 whenever hold_vld=0.
- Acceptance condition: can_acc = (!hold_vld | fifo_wr_en) & (outstanding < MAX_OUTSTANDING).
  - This gives full throughput of one ID per cycle while the FIFO is not full.
- Arbitration, round robin:
  - Only awvalid: grant AW. Only arvalid: grant AR.
  - Both valid: grant the channel not equal to last_grant. After reset, write wins first.
  - last_grant updates only on an actual accept.
- Ready outputs:
  - awready = can_acc & grant_aw; arready = can_acc & grant_ar.
  - Never both high in the same cycle.
  - Ready depends on valid; this is permitted by AXI.
- On accept (valid & ready): hold_data <= {1'b1, awid} or {1'b0, arid}; hold_vld <= 1; outstanding increments.
- If fifo_wr_en is high and there is no accept in that cycle: hold_vld <= 0.
- Latency: an ID accepted in cycle N appears on fifo_data/fifo_wr_en in cycle N+1, if the FIFO is not full.
- FIFO full: the entry is held and fifo_wr_en stays low. Ready falls as soon as the holding register is occupied. No entry is ever dropped or duplicated.
- Outstanding counter:
  - +1 on accept; -1 on rsp_done.
  - Accept and rsp_done in the same cycle: unchanged.
  - The counter counts the held entry, so MAX_OUTSTANDING also bounds FIFO occupancy.
- At outstanding == MAX_OUTSTANDING: both readies are 0. A simultaneous rsp_done does not open acceptance until the next cycle, because the counter is registered.
- rsp_done at outstanding == 0 (with no accept in the same cycle): counter stays 0, err_underflow <= 1 until reset.
- Width rule: the counter never wraps. Increment is blocked at MAX and decrement is blocked at 0.
- Reset mid-operation: the holding register and counter are discarded immediately. The FIFO must be reset by the same resetn.

Decomposition:
- Shared package axi2ahb_pkg:
  - AXI_ID_WIDTH default.
  - ID FIFO depth constant (128), reused as MAX_OUTSTANDING.
  - Entry field positions: IS_WRITE_BIT = AXI_ID_WIDTH.
  - Grant encoding constants GRANT_WRITE / GRANT_READ.
- One natural sub-module: axi_id_rr_arb2, a two-requester round-robin arbiter with last_grant state, reusable for the response-side merge.
- Holding register and counter stay in the top module.

Test Plan:
- Reset, then awvalid=1, awid=0x5A, fifo_full=0 -> awready=1 in cycle 0; cycle 1: fifo_wr_en=1, fifo_data=0x15A; outstanding=1.
- awvalid and arvalid held for 4 cycles, awid=0x01, arid=0x02 -> FIFO entries 0x101, 0x002, 0x101, 0x002; grants alternate with no idle cycle.
- fifo_full=1 for 5 cycles with one held entry 0x033 -> fifo_wr_en=0 and both readies 0 throughout; a single write of 0x033 follows full deassertion.
- Issue 128 accepts with no rsp_done -> outstanding=128 and both readies 0; one rsp_done pulse -> outstanding=127, readies reopen the next cycle.
- Accept and rsp_done in the same cycle at outstanding=10 -> outstanding stays 10.
- rsp_done at outstanding=0 -> err_underflow=1 and stays set; outstanding=0; assert resetn mid-stream -> all outputs return to 0 asynchronously.
